comb_one: RTL and testbench
===========================

COMB_ONE -- requirements
Module: comb_one

Interface
REQ-001 Parameter X_POS, default 2, router column in the 8x8 mesh (0..7).
REQ-002 Parameter Y_POS, default 2, router row in the 8x8 mesh (0..7).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 nin, ein, sin, win  input  10 each  network flits arriving from the north, east, south and west neighbours.
REQ-006 lin  input  10  local injection flit.
REQ-007 nout, eout, sout, wout  output  10 each  registered network flits sent to the neighbours.
REQ-008 lout  output  10  registered ejected flit delivered to the local node.
REQ-009 lack  output  1  combinational; high when the valid lin is accepted in the current cycle.

Function
REQ-010 Flit format SHALL be [9] valid, [8:6] dst_x, [5:3] dst_y, [2:0] age; an invalid flit SHALL be presented as 10'h000 on every output.
REQ-011 Each valid flit SHALL have a productive port by XY routing: E if dst_x>X_POS, W if dst_x<X_POS, else N if dst_y>Y_POS, S if dst_y<Y_POS, else L.
REQ-012 Priority order SHALL be higher age first; ties SHALL be broken by fixed order N, E, S, W, L.
REQ-013 Ejection: at most one flit per cycle; the highest-priority L-destined network flit SHALL go to lout; other L-destined flits SHALL be deflected.
REQ-014 Injection: lin SHALL be accepted only if at least one network output is free after ejection; lack=lin[9] and free-slot; a rejected lin is dropped, and the source retries.
REQ-015 Allocation SHALL process flits in priority order: each takes its productive output if free, else the first free output in order N, E, S, W.
REQ-016 The router is bufferless: every valid network input SHALL leave on exactly one output in the same cycle; no flit is lost or duplicated.
REQ-017 A deflected flit SHALL have its age incremented, saturating at 7; non-deflected and ejected flits keep their age.
REQ-018 Latency SHALL be exactly one clock: outputs register the allocation result computed from the current-cycle inputs.

Reset
REQ-019 While rst=1 at a rising edge, nout, eout, sout, wout and lout SHALL become 10'h000.
REQ-020 Reset asserted mid-operation SHALL discard in-flight flits; lack SHALL be 0 while rst=1.

Configuration
REQ-021 With COMB_ONE_AGE_PRIO_EN defined, REQ-012 and REQ-017 apply.
REQ-022 Without COMB_ONE_AGE_PRIO_EN:
- priority SHALL be fixed N>E>S>W>L;
- the age field SHALL pass through unmodified.

Structure
REQ-023 Package comb_one_pkg SHALL hold:
- flit width and field positions;
- a port enum (N, E, S, W, L);
- the invalid-flit constant.
REQ-024 Sub-module comb_one_route SHALL compute the productive port of one flit; it is instantiated five times.

Verification (X_POS=2, Y_POS=2, COMB_ONE_AGE_PRIO_EN defined)
REQ-025 nin=10'h350, other inputs 0 -> eout=10'h350 one cycle later; other outputs 0.
REQ-026 nin=10'h353, sin=10'h351 (both to E) -> eout=10'h353 and nout=10'h352 (deflected, age incremented).
REQ-027 win=10'h290 (dst 2,2) -> lout=10'h290 next cycle; network outputs 0.
REQ-028 Ejection conflict and full-load injection:
- nin, ein, sin, win all valid toward E, lin=10'h350 -> lack=0 and four network outputs valid;
- with win=0, lack=1 and the injected flit occupies the remaining free output.
REQ-029 Traffic present, then rst=1 for one edge -> all outputs 10'h000 after that edge; normal routing resumes on the first edge after rst=0.

Source files
------------

// File: rtl/comb_one_pkg.sv
// Shared flit layout, port encoding and helpers for the comb_one deflection router.
package comb_one_pkg;

  localparam int FLIT_W    = 10;
  localparam int VALID_BIT = 9;
  localparam int DX_HI     = 8;
  localparam int DX_LO     = 6;
  localparam int DY_HI     = 5;
  localparam int DY_LO     = 3;
  localparam int AGE_HI    = 2;
  localparam int AGE_LO    = 0;
  localparam int COORD_W   = 3;
  localparam int AGE_W     = 3;
  localparam int NUM_IN    = 5;
  localparam int NUM_NET   = 4;
  localparam int RANK_W    = 3;

  localparam logic [FLIT_W-1:0] FLIT_INVALID = '0;
  localparam logic [AGE_W-1:0]  AGE_MAX      = 3'd7;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  function automatic logic [AGE_W-1:0] age_bump(input logic [AGE_W-1:0] age);
    return (age == AGE_MAX) ? age : age + 1'b1;
  endfunction

endpackage

// File: rtl/comb_one_route.sv
// XY route computation: X dimension first, then Y, local when both coordinates match.
module comb_one_route
  import comb_one_pkg::*;
#(
  parameter int X_POS = 2,
  parameter int Y_POS = 2
) (
  input  logic [COORD_W-1:0] dst_x,
  input  logic [COORD_W-1:0] dst_y,
  output port_e              port
);

  localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_POS);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_POS);

  always_comb begin
    if (dst_x > MY_X) begin
      port = PORT_E;
    end else if (dst_x < MY_X) begin
      port = PORT_W;
    end else if (dst_y > MY_Y) begin
      port = PORT_N;
    end else if (dst_y < MY_Y) begin
      port = PORT_S;
    end else begin
      port = PORT_L;
    end
  end

endmodule

// File: rtl/comb_one.sv
// Bufferless single-cycle deflection router for an 8x8 mesh.
// Define COMB_ONE_AGE_PRIO_EN for oldest-first priority with age increment on deflection.
module comb_one
  import comb_one_pkg::*;
#(
  parameter int X_POS = 2,
  parameter int Y_POS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] nin,
  input  logic [FLIT_W-1:0] ein,
  input  logic [FLIT_W-1:0] sin,
  input  logic [FLIT_W-1:0] win,
  input  logic [FLIT_W-1:0] lin,
  output logic [FLIT_W-1:0] nout,
  output logic [FLIT_W-1:0] eout,
  output logic [FLIT_W-1:0] sout,
  output logic [FLIT_W-1:0] wout,
  output logic [FLIT_W-1:0] lout,
  output logic              lack
);

  logic [FLIT_W-1:0] raw   [NUM_IN];
  logic [FLIT_W-1:0] flit  [NUM_IN];
  port_e             prod  [NUM_IN];
  logic [RANK_W-1:0] rank  [NUM_IN];
  logic [FLIT_W-1:0] out_d [NUM_IN];
  logic [FLIT_W-1:0] out_q [NUM_IN];

  logic [NUM_NET-1:0] net_valid;
  logic [NUM_NET-1:0] net_local;
  logic               net_full;
  logic               lin_ok;

  assign raw[0] = nin;
  assign raw[1] = ein;
  assign raw[2] = sin;
  assign raw[3] = win;
  assign raw[4] = lin;

  // Routing uses the raw local flit so acceptance never feeds back into routing.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_route
      comb_one_route #(
        .X_POS (X_POS),
        .Y_POS (Y_POS)
      ) u_route (
        .dst_x (raw[gi][DX_HI:DX_LO]),
        .dst_y (raw[gi][DY_HI:DY_LO]),
        .port  (prod[gi])
      );
    end

    for (genvar gi = 0; gi < NUM_NET; gi++) begin : g_net
      assign net_valid[gi] = raw[gi][VALID_BIT];
      assign net_local[gi] = net_valid[gi] && (prod[gi] == PORT_L);
      assign flit[gi]      = raw[gi];
    end
  endgenerate

  // All four links are needed only when every neighbour sends and none ejects.
  assign net_full      = (&net_valid) & ~(|net_local);
  assign lin_ok        = lin[VALID_BIT] & ~net_full;
  assign lack          = lin_ok & ~rst;
  assign flit[NUM_NET] = lin_ok ? lin : FLIT_INVALID;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_IN; j++) begin
        if (j != i) begin
`ifdef COMB_ONE_AGE_PRIO_EN
          if ((flit[j][AGE_HI:AGE_LO] > flit[i][AGE_HI:AGE_LO]) ||
              ((flit[j][AGE_HI:AGE_LO] == flit[i][AGE_HI:AGE_LO]) && (j < i))) begin
            rank[i] = rank[i] + 1'b1;
          end
`else
          if (j < i) begin
            rank[i] = rank[i] + 1'b1;
          end
`endif
        end
      end
    end
  end

  logic [NUM_IN-1:0] taken;
  logic [2:0]        sel;
  logic [2:0]        dest;
  logic              granted;
  logic [FLIT_W-1:0] cur;
  port_e             cur_port;

  always_comb begin
    taken    = '0;
    sel      = '0;
    dest     = '0;
    granted  = 1'b0;
    cur      = FLIT_INVALID;
    cur_port = PORT_L;
    for (int k = 0; k < NUM_IN; k++) begin
      out_d[k] = FLIT_INVALID;
    end
    for (int p = 0; p < NUM_IN; p++) begin
      sel = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (rank[i] == RANK_W'(p)) begin
          sel = 3'(i);
        end
      end
      cur      = flit[sel];
      cur_port = prod[sel];
      dest     = '0;
      granted  = 1'b0;
      if (cur[VALID_BIT]) begin
        // Only network flits may eject; a local flit addressed to itself is deflected.
        if (cur_port == PORT_L) begin
          if ((sel != 3'(NUM_NET)) && !taken[PORT_L]) begin
            dest    = 3'(PORT_L);
            granted = 1'b1;
          end
        end else if (!taken[cur_port]) begin
          dest    = 3'(cur_port);
          granted = 1'b1;
        end
        if (!granted) begin
          for (int k = NUM_NET - 1; k >= 0; k--) begin
            if (!taken[k]) begin
              dest = 3'(k);
            end
          end
`ifdef COMB_ONE_AGE_PRIO_EN
          cur[AGE_HI:AGE_LO] = age_bump(cur[AGE_HI:AGE_LO]);
`endif
        end
        taken[dest] = 1'b1;
        out_d[dest] = cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_IN; k++) begin
        out_q[k] <= FLIT_INVALID;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        out_q[k] <= out_d[k];
      end
    end
  end

  assign nout = out_q[PORT_N];
  assign eout = out_q[PORT_E];
  assign sout = out_q[PORT_S];
  assign wout = out_q[PORT_W];
  assign lout = out_q[PORT_L];

endmodule

// File: tb/tb_comb_one.sv
// Directed table plus randomized check of comb_one against a sort-and-allocate reference model.
module tb_comb_one;

  localparam int XP = 2;
  localparam int YP = 2;
`ifdef COMB_ONE_AGE_PRIO_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] nin, ein, sin, win, lin;
  logic [9:0] nout, eout, sout, wout, lout;
  logic       lack;

  int n_checks = 0;
  int n_fail   = 0;

  comb_one #(.X_POS(XP), .Y_POS(YP)) dut (
    .clk  (clk),
    .rst  (rst),
    .nin  (nin),
    .ein  (ein),
    .sin  (sin),
    .win  (win),
    .lin  (lin),
    .nout (nout),
    .eout (eout),
    .sout (sout),
    .wout (wout),
    .lout (lout),
    .lack (lack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0][9:0] stim;
    logic [4:0][9:0] exp_o;
    logic            exp_ack;
  } vec_t;

  function automatic logic [4:0][9:0] pk(input logic [9:0] n, e, s, w, l);
    return {l, w, s, e, n};
  endfunction

  function automatic int prod_port(input logic [9:0] f);
    int x = int'(f[8:6]);
    int y = int'(f[5:3]);
    if (x > XP) return 1;
    if (x < XP) return 3;
    if (y > YP) return 0;
    if (y < YP) return 2;
    return 4;
  endfunction

  // Reference: pick accepted flits, sort by priority, then hand out ports greedily.
  function automatic void model(input logic [4:0][9:0] in, output logic [4:0][9:0] o,
                                output logic ack);
    int order [5];
    int score [5];
    bit free_p [5];
    int cnt, nv, ej, tmp, i, p, dst;
    logic [9:0] f;
    cnt = 0; nv = 0; ej = 0;
    o = '0;
    for (int k = 0; k < 5; k++) free_p[k] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (in[k][9]) begin
        nv++;
        if (prod_port(in[k]) == 4) ej = 1;
      end
    end
    ack = in[4][9] && ((nv - ej) < 4);
    for (int k = 0; k < 5; k++) begin
      if (in[k][9] && (k < 4 || ack)) begin
        order[cnt] = k;
        score[cnt] = (AGE_ON ? int'(in[k][2:0]) * 16 : 0) + (15 - k);
        cnt++;
      end
    end
    for (int a = 0; a < cnt; a++) begin
      for (int b = a + 1; b < cnt; b++) begin
        if (score[b] > score[a]) begin
          tmp = score[a]; score[a] = score[b]; score[b] = tmp;
          tmp = order[a]; order[a] = order[b]; order[b] = tmp;
        end
      end
    end
    for (int t = 0; t < cnt; t++) begin
      i   = order[t];
      f   = in[i];
      p   = prod_port(f);
      dst = -1;
      if (p == 4) begin
        if (i < 4 && free_p[4]) dst = 4;
      end else if (free_p[p]) begin
        dst = p;
      end
      if (dst < 0) begin
        for (int k = 0; k < 4; k++) if (free_p[k] && dst < 0) dst = k;
        if (AGE_ON && f[2:0] != 3'd7) f[2:0] = f[2:0] + 3'd1;
      end
      if (dst >= 0) begin
        free_p[dst] = 1'b0;
        o[dst] = f;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %03h, expected %03h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic [4:0][9:0] s);
    nin = s[0]; ein = s[1]; sin = s[2]; win = s[3]; lin = s[4];
  endtask

  task automatic check_outs(input string tag, input logic [4:0][9:0] e);
    chk({tag, ".nout"}, nout, e[0]);
    chk({tag, ".eout"}, eout, e[1]);
    chk({tag, ".sout"}, sout, e[2]);
    chk({tag, ".wout"}, wout, e[3]);
    chk({tag, ".lout"}, lout, e[4]);
  endtask

  task automatic run_vec(input string tag, input logic [4:0][9:0] s,
                         input logic [4:0][9:0] e, input logic e_ack);
    @(negedge clk);
    drive(s);
    #1;
    chk({tag, ".lack"}, {9'd0, lack}, {9'd0, e_ack});
    @(posedge clk);
    #1;
    check_outs(tag, e);
    $display("%s: in n=%03h e=%03h s=%03h w=%03h l=%03h -> out n=%03h e=%03h s=%03h w=%03h l=%03h lack=%0b",
             tag, s[0], s[1], s[2], s[3], s[4], nout, eout, sout, wout, lout, e_ack);
  endtask

  function automatic logic [9:0] rnd_flit(input bit allow_local);
    logic [2:0] x, y, a;
    if ($urandom_range(0, 3) == 0) return 10'h000;
    x = 3'($urandom_range(0, 7));
    y = 3'($urandom_range(0, 7));
    a = 3'($urandom_range(0, 7));
    if (!allow_local && x == 3'(XP) && y == 3'(YP)) x = 3'(XP + 1);
    return {1'b1, x, y, a};
  endfunction

  vec_t tbl [10];
  logic [4:0][9:0] s_r, e_r;
  logic            a_r;

  initial begin
    tbl[0] = '{pk(10'h350, 0, 0, 0, 0), pk(0, 10'h350, 0, 0, 0), 1'b0};
    tbl[1] = '{pk(10'h353, 0, 10'h351, 0, 0),
               pk(AGE_ON ? 10'h352 : 10'h351, 10'h353, 0, 0, 0), 1'b0};
    tbl[2] = '{pk(0, 0, 0, 10'h290, 0), pk(0, 0, 0, 0, 10'h290), 1'b0};
    tbl[3] = '{pk(10'h350, 10'h350, 10'h350, 10'h350, 10'h350),
               AGE_ON ? pk(10'h351, 10'h350, 10'h351, 10'h351, 0)
                      : pk(10'h350, 10'h350, 10'h350, 10'h350, 0), 1'b0};
    tbl[4] = '{pk(10'h350, 10'h350, 10'h350, 0, 10'h352),
               AGE_ON ? pk(10'h351, 10'h352, 10'h351, 10'h351, 0)
                      : pk(10'h350, 10'h350, 10'h350, 10'h352, 0), 1'b1};
    tbl[5] = '{pk(10'h290, 10'h291, 0, 0, 0),
               AGE_ON ? pk(10'h291, 0, 0, 0, 10'h291)
                      : pk(10'h291, 0, 0, 0, 10'h290), 1'b0};
    tbl[6] = '{pk(10'h357, 10'h357, 0, 0, 0), pk(10'h357, 10'h357, 0, 0, 0), 1'b0};
    tbl[7] = '{pk(0, 0, 0, 0, 10'h210), pk(0, 0, 0, 10'h210, 0), 1'b1};
    tbl[8] = '{pk(0, 10'h281, 10'h2A8, 0, 0), pk(10'h2A8, 0, 10'h281, 0, 0), 1'b0};
    tbl[9] = '{pk(10'h290, 10'h290, 10'h290, 10'h290, 10'h350),
               AGE_ON ? pk(10'h291, 10'h291, 10'h291, 10'h351, 10'h290)
                      : pk(10'h290, 10'h290, 10'h290, 10'h350, 10'h290), 1'b1};

    rst = 1'b1;
    drive(pk(0, 0, 0, 0, 10'h350));
    #1;
    chk("reset.lack", {9'd0, lack}, 10'd0);
    @(posedge clk);
    #1;
    check_outs("reset", '0);
    $display("reset: outputs n=%03h e=%03h s=%03h w=%03h l=%03h", nout, eout, sout, wout, lout);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_vec($sformatf("vec%0d", v), tbl[v].stim, tbl[v].exp_o, tbl[v].exp_ack);
    end

    // Mid-traffic reset, then recovery on the first edge after release.
    run_vec("pre_rst", pk(10'h350, 0, 0, 10'h290, 0), pk(0, 10'h350, 0, 0, 10'h290), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(pk(10'h350, 0, 0, 0, 10'h210));
    #1;
    chk("mid_rst.lack", {9'd0, lack}, 10'd0);
    @(posedge clk);
    #1;
    check_outs("mid_rst", '0);
    $display("mid_rst: outputs n=%03h e=%03h s=%03h w=%03h l=%03h", nout, eout, sout, wout, lout);
    @(negedge clk);
    rst = 1'b0;
    run_vec("post_rst", pk(10'h350, 0, 0, 0, 10'h210), pk(0, 10'h350, 0, 10'h210, 0), 1'b1);

    for (int c = 0; c < 400; c++) begin
      s_r = pk(rnd_flit(1'b1), rnd_flit(1'b1), rnd_flit(1'b1), rnd_flit(1'b1), rnd_flit(1'b0));
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        drive(s_r);
        #1;
        chk($sformatf("rnd%0d_rst.lack", c), {9'd0, lack}, 10'd0);
        @(posedge clk);
        #1;
        check_outs($sformatf("rnd%0d_rst", c), '0);
        $display("rnd%0d: reset cycle", c);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        model(s_r, e_r, a_r);
        run_vec($sformatf("rnd%0d", c), s_r, e_r, a_r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
